// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU result-drain path.
package tpu_pkg;

    // Drain controller states
    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_RUN  = 2'd1,
        DR_FIN  = 2'd2
    } drain_state_t;

    // Matrix scan order: which index is the fast (inner) dimension
    typedef enum logic {
        SCAN_ROW = 1'b0,
        SCAN_COL = 1'b1
    } scan_order_t;

    // Index width for a dimension of n entries; a dimension of 1 still gets a 1-bit index
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tpu_scan_counter.sv
// 2-D row/column position counter for the result drain.
// Holds the position of the beat currently presented (registered), and exposes
// the position of the beat that will be presented next (combinational) so the
// top level can register the matching data in the same edge.
module tpu_scan_counter
    import tpu_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int LANES = 1,
    localparam int RW   = idx_w(ROWS),
    localparam int CW   = idx_w(COLS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,      // restart at (0,0) with a new scan order
    input  logic        advance,    // step to the following beat position
    input  scan_order_t order_in,   // scan order taken on clear
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic        is_last,
    output logic [RW-1:0] nxt_row,
    output logic [CW-1:0] nxt_col,
    output scan_order_t nxt_order
);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_WRAP = RW'(ROWS - LANES);
    localparam logic [RW-1:0] ROW_STEP = RW'(LANES);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_WRAP = CW'(COLS - LANES);
    localparam logic [CW-1:0] COL_STEP = CW'(LANES);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);

    scan_order_t   order_r;
    scan_order_t   order_s;
    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic          last_r;
    logic [RW-1:0] nxt_row_s;
    logic [CW-1:0] nxt_col_s;

    // True when (r,c) is the final beat position of a drain in order o
    function automatic logic last_f(input logic [RW-1:0] r,
                                    input logic [CW-1:0] c,
                                    input scan_order_t   o);
        logic res;
        case (o)
            SCAN_ROW: res = (r == ROW_LAST) && (c == COL_WRAP);
            SCAN_COL: res = (c == COL_LAST) && (r == ROW_WRAP);
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

    // Next position: clear wins, then a LANES step in the inner dimension with wrap
    always_comb begin
        order_s   = order_r;
        nxt_row_s = row_r;
        nxt_col_s = col_r;
        if (clear) begin
            order_s   = order_in;
            nxt_row_s = '0;
            nxt_col_s = '0;
        end else if (advance) begin
            case (order_r)
                SCAN_ROW: begin
                    if (col_r == COL_WRAP) begin
                        nxt_col_s = '0;
                        if (row_r == ROW_LAST) begin
                            nxt_row_s = '0;
                        end else begin
                            nxt_row_s = row_r + ROW_ONE;
                        end
                    end else begin
                        nxt_col_s = col_r + COL_STEP;
                    end
                end
                SCAN_COL: begin
                    if (row_r == ROW_WRAP) begin
                        nxt_row_s = '0;
                        if (col_r == COL_LAST) begin
                            nxt_col_s = '0;
                        end else begin
                            nxt_col_s = col_r + COL_ONE;
                        end
                    end else begin
                        nxt_row_s = row_r + ROW_STEP;
                    end
                end
                default: begin
                    nxt_row_s = row_r;
                    nxt_col_s = col_r;
                end
            endcase
        end else begin
            nxt_row_s = row_r;
            nxt_col_s = col_r;
        end
    end

    // Position, last flag and scan order registers
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r   <= '0;
            col_r   <= '0;
            last_r  <= 1'b0;
            order_r <= SCAN_ROW;
        end else begin
            row_r   <= nxt_row_s;
            col_r   <= nxt_col_s;
            last_r  <= last_f(nxt_row_s, nxt_col_s, order_s);
            order_r <= order_s;
        end
    end

    assign row       = row_r;
    assign col       = col_r;
    assign is_last   = last_r;
    assign nxt_row   = nxt_row_s;
    assign nxt_col   = nxt_col_s;
    assign nxt_order = order_s;

endmodule

// File: rtl/tpu_result_drain.sv
// Drains the systolic-array accumulator matrix onto a valid/ready stream,
// LANES elements per beat, in row-major or column-major order after one start.
// All stream outputs are registered; the next beat is loaded in the same edge
// as a transfer so a continuously-ready sink sees one beat per cycle.
module tpu_result_drain
    import tpu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int LANES = 1,
    localparam int RW   = idx_w(ROWS),
    localparam int CW   = idx_w(COLS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               col_major,
    input  logic                               abort,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0]  data_in,
    output logic                               busy,
    output logic                               done,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [LANES*DW-1:0]                m_data,
    output logic [RW-1:0]                      m_row,
    output logic [CW-1:0]                      m_col,
    output logic                               m_last
);

    drain_state_t        state_r;
    drain_state_t        state_nxt_s;
    logic                valid_r;
    logic                busy_r;
    logic                done_r;
    logic [LANES*DW-1:0] data_r;
    logic [LANES*DW-1:0] lane_data_s;
    logic                xfer_s;
    logic                accept_s;
    logic                advance_s;
    logic                last_s;
    scan_order_t         order_in_s;
    scan_order_t         nxt_order_s;
    logic [RW-1:0]       row_s;
    logic [CW-1:0]       col_s;
    logic [RW-1:0]       nxt_row_s;
    logic [CW-1:0]       nxt_col_s;
    logic [RW-1:0]       r_sel_s;
    logic [CW-1:0]       c_sel_s;

    assign order_in_s = col_major ? SCAN_COL : SCAN_ROW;
    assign xfer_s     = valid_r && m_ready;
    assign accept_s   = (state_r == DR_IDLE) && start;
    // Step only on a non-final transfer that is not being cancelled
    assign advance_s  = (state_r == DR_RUN) && xfer_s && !last_s && !abort;

    tpu_scan_counter #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .LANES (LANES)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept_s),
        .advance   (advance_s),
        .order_in  (order_in_s),
        .row       (row_s),
        .col       (col_s),
        .is_last   (last_s),
        .nxt_row   (nxt_row_s),
        .nxt_col   (nxt_col_s),
        .nxt_order (nxt_order_s)
    );

    // Next-state logic: abort outranks the final handshake, so abort+last gives no done
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DR_IDLE: begin
                if (start) begin
                    state_nxt_s = DR_RUN;
                end else begin
                    state_nxt_s = DR_IDLE;
                end
            end
            DR_RUN: begin
                if (abort) begin
                    state_nxt_s = DR_IDLE;
                end else if (xfer_s && last_s) begin
                    state_nxt_s = DR_FIN;
                end else begin
                    state_nxt_s = DR_RUN;
                end
            end
            DR_FIN: begin
                state_nxt_s = DR_IDLE;
            end
            default: begin
                state_nxt_s = DR_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DR_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Lane mux: gather LANES elements starting at the next beat position
    always_comb begin
        lane_data_s = '0;
        r_sel_s     = nxt_row_s;
        c_sel_s     = nxt_col_s;
        for (int k = 0; k < LANES; k++) begin
            if (nxt_order_s == SCAN_COL) begin
                r_sel_s = nxt_row_s + RW'(k);
                c_sel_s = nxt_col_s;
            end else begin
                r_sel_s = nxt_row_s;
                c_sel_s = nxt_col_s + CW'(k);
            end
            lane_data_s[k*DW +: DW] = data_in[r_sel_s][c_sel_s];
        end
    end

    // Output register stage: status flags follow the next state, data loads on start or step
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            data_r  <= '0;
        end else begin
            valid_r <= (state_nxt_s == DR_RUN);
            busy_r  <= (state_nxt_s == DR_RUN);
            done_r  <= (state_nxt_s == DR_FIN);
            if (accept_s || advance_s) begin
                data_r <= lane_data_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign m_valid = valid_r;
    assign m_data  = data_r;
    assign m_row   = row_s;
    assign m_col   = col_s;
    assign m_last  = last_s;

endmodule

// File: tb/tb_tpu_result_drain.sv
// Scoreboard bench for tpu_result_drain: a LANES=1 and a LANES=2 instance on a
// 4x4 matrix share stimulus; a reference model builds each drain's beat list
// from the scan rules and a negedge monitor compares every presented beat.
module tb_tpu_result_drain;

    localparam int DW = 32;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst, start, col_major, abort, m_ready;
    logic [N-1:0][N-1:0][DW-1:0] data_in;

    logic        a_busy, a_done, a_valid, a_last;
    logic [31:0] a_data;
    logic [1:0]  a_row, a_col;
    logic        b_busy, b_done, b_valid, b_last;
    logic [63:0] b_data;
    logic [1:0]  b_row, b_col;

    typedef struct {
        logic [63:0] data;
        int          row;
        int          col;
        bit          last;
    } beat_t;

    beat_t       q0[$];
    beat_t       q1[$];
    int          st[2];     // model state: 0 idle, 1 draining, 2 done cycle
    int          xcnt[2];   // transfers since the last accepted start
    logic [31:0] mat[N][N];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rmode    = 1'b0;

    tpu_result_drain #(.DW(DW), .ROWS(N), .COLS(N), .LANES(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .col_major(col_major), .abort(abort),
        .data_in(data_in), .busy(a_busy), .done(a_done), .m_valid(a_valid),
        .m_ready(m_ready), .m_data(a_data), .m_row(a_row), .m_col(a_col), .m_last(a_last)
    );

    tpu_result_drain #(.DW(DW), .ROWS(N), .COLS(N), .LANES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .col_major(col_major), .abort(abort),
        .data_in(data_in), .busy(b_busy), .done(b_done), .m_valid(b_valid),
        .m_ready(m_ready), .m_data(b_data), .m_row(b_row), .m_col(b_col), .m_last(b_last)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat list for one drain, straight from the scan-order rules
    task automatic build(input int id, input bit cm);
        int    l;
        beat_t b;
        l = (id == 0) ? 1 : 2;
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i += l) begin
                b.data = '0;
                for (int k = 0; k < l; k++) begin
                    if (cm) b.data |= 64'(mat[i+k][o]) << (32 * k);
                    else    b.data |= 64'(mat[o][i+k]) << (32 * k);
                end
                b.row  = cm ? i : o;
                b.col  = cm ? o : i;
                b.last = (o == N - 1) && (i == N - l);
                if (id == 0) q0.push_back(b);
                else         q1.push_back(b);
            end
        end
    endtask

    // Compare one instance against the model for this cycle, then advance the model
    task automatic step(input int id, input logic [63:0] data, input int row, input int col,
                        input logic last, input logic valid, input logic busy, input logic done);
        beat_t f;
        bit    has;
        string p;
        p   = (id == 0) ? "L1" : "L2";
        has = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (has) f = (id == 0) ? q0[0] : q1[0];
        chk({p, " m_valid"}, {63'd0, valid}, {63'd0, st[id] == 1});
        chk({p, " busy"},    {63'd0, busy},  {63'd0, st[id] == 1});
        chk({p, " done"},    {63'd0, done},  {63'd0, st[id] == 2});
        if (st[id] == 1) begin
            if (has) begin
                chk({p, " m_data"}, data, f.data);
                chk({p, " m_row"}, 64'(row), 64'(f.row));
                chk({p, " m_col"}, 64'(col), 64'(f.col));
                chk({p, " m_last"}, {63'd0, last}, {63'd0, f.last});
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL %s beat: got a beat while expecting none", p);
            end
        end
        if (rst) begin
            if (id == 0) q0.delete(); else q1.delete();
            st[id] = 0;
        end else begin
            case (st[id])
                0: if (start) begin
                    build(id, col_major);
                    st[id]   = 1;
                    xcnt[id] = 0;
                end
                1: if (abort) begin
                    if (id == 0) q0.delete(); else q1.delete();
                    st[id] = 0;
                end else if (m_ready && has) begin
                    if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    xcnt[id]++;
                    st[id] = f.last ? 2 : 1;
                end
                default: st[id] = 0;
            endcase
        end
    endtask

    always @(negedge clk) begin
        step(0, {32'd0, a_data}, int'(a_row), int'(a_col), a_last, a_valid, a_busy, a_done);
        step(1, b_data, int'(b_row), int'(b_col), b_last, b_valid, b_busy, b_done);
    end

    // Downstream ready: always high, or randomly stalling
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic load_mat(input bit rnd);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mat[r][c]     = rnd ? $urandom : 32'(16 * r + c);
                data_in[r][c] = mat[r][c];
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_drain(input bit cm);
        col_major = cm;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic timeout(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", what);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((st[0] != 0 || st[1] != 0) && cyc < 2000) begin
            tick();
            cyc++;
        end
        if (cyc >= 2000) timeout("wait_idle");
        tick();
    endtask

    task automatic wait_xfer(input int n);
        int cyc = 0;
        while (xcnt[0] < n && cyc < 2000) begin
            tick();
            cyc++;
        end
        if (cyc >= 2000) timeout("wait_xfer");
    endtask

    task automatic check_zero();
        @(negedge clk);
        chk("rst L1 m_data", {32'd0, a_data}, 64'd0);
        chk("rst L1 m_row",  64'(a_row), 64'd0);
        chk("rst L1 m_col",  64'(a_col), 64'd0);
        chk("rst L1 m_last", {63'd0, a_last}, 64'd0);
        chk("rst L2 m_data", b_data, 64'd0);
        chk("rst L2 m_row",  64'(b_row), 64'd0);
        chk("rst L2 m_col",  64'(b_col), 64'd0);
        chk("rst L2 m_last", {63'd0, b_last}, 64'd0);
        tick();
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; col_major = 1'b0; abort = 1'b0;
        st[0] = 0; st[1] = 0; xcnt[0] = 0; xcnt[1] = 0;
        load_mat(1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_zero();

        // Fixed matrix, both orders, ready high then stalling
        start_drain(1'b0); wait_idle();
        start_drain(1'b1); wait_idle();
        rmode = 1'b1;
        start_drain(1'b0); wait_idle();
        start_drain(1'b1); wait_idle();
        rmode = 1'b0;

        // Abort after 5 transfers, then a fresh drain from (0,0)
        start_drain(1'b0); wait_xfer(5);
        abort = 1'b1; tick(); abort = 1'b0;
        wait_idle();
        start_drain(1'b0); wait_idle();

        // Abort coinciding with the final handshake of the LANES=2 instance
        start_drain(1'b0);
        cyc = 0;
        while (!(st[1] == 1 && q1.size() == 1) && cyc < 200) begin tick(); cyc++; end
        if (cyc >= 200) timeout("abort_last");
        abort = 1'b1; tick(); abort = 1'b0;
        wait_idle();

        // start during RUN is ignored; start during FIN is ignored
        start_drain(1'b1); wait_xfer(4);
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (st[0] != 2 && cyc < 200) begin tick(); cyc++; end
        if (cyc >= 200) timeout("fin_start");
        start = 1'b1; tick(); start = 1'b0;
        wait_idle();

        // Reset mid-drain
        start_drain(1'b0); wait_xfer(3);
        rst = 1'b1; tick(); rst = 1'b0;
        check_zero();

        // Random matrices, orders and stalls
        for (int t = 0; t < 8; t++) begin
            load_mat(1'b1);
            rmode = $urandom_range(0, 1);
            start_drain($urandom_range(0, 1));
            wait_idle();
        end
        rmode = 1'b0;
        tick();
        chk("L1 leftover beats", 64'(q0.size()), 64'd0);
        chk("L2 leftover beats", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
